// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-stage load/store bus controller.
// State encodings are kept as plain 2-bit constants so legacy code that shares them still works.
package mem_access_ctrl_pkg;

   localparam logic [1:0] MAC_IDLE = 2'd0;
   localparam logic [1:0] MAC_REQ  = 2'd1;
   localparam logic [1:0] MAC_RDW  = 2'd2;
   localparam logic [1:0] MAC_DONE = 2'd3;

endpackage

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store bus controller: computes the effective address, runs the
// word-aligned request handshake, and captures load data for the extender.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [31:0] base,
   input  logic [15:0] offset,
   input  logic [31:0] st_data,
   input  logic [3:0]  st_strb,
   output logic [31:0] Address,
   output logic        MemRead,
   output logic        MemWrite,
   input  logic        Address_Ready,
   output logic [31:0] Write_data,
   output logic [3:0]  Write_strb,
   input  logic [31:0] Read_data,
   input  logic        Read_data_Valid,
   output logic        Read_data_Ready,
   output logic [31:0] mem_data,
   output logic [1:0]  ea,
   output logic        busy,
   output logic        done
);

   logic [1:0]  state_q, state_d;
   logic [31:0] address_q, address_d;
   logic [1:0]  ea_q, ea_d;
   logic [31:0] mem_data_q, mem_data_d;
   logic        op_load_q, op_load_d;
   logic [31:0] eff;
   logic        in_req;

   always_comb begin
      eff = base + {{16{offset[15]}}, offset};
   end

   always_comb begin
      state_d    = state_q;
      address_d  = address_q;
      ea_d       = ea_q;
      mem_data_d = mem_data_q;
      op_load_d  = op_load_q;
      case (state_q)
         MAC_IDLE: begin
            if (start) begin
               if (is_load || is_store) begin
                  address_d = {eff[31:2], 2'b00};
                  ea_d      = eff[1:0];
                  // A load flag wins when both flags are set.
                  op_load_d = is_load;
                  state_d   = MAC_REQ;
               end else begin
                  state_d = MAC_DONE;
               end
            end
         end
         MAC_REQ: begin
            if (Address_Ready) begin
               state_d = op_load_q ? MAC_RDW : MAC_DONE;
            end
         end
         MAC_RDW: begin
            if (Read_data_Valid) begin
               mem_data_d = Read_data;
               state_d    = MAC_DONE;
            end
         end
         MAC_DONE: begin
            state_d = MAC_IDLE;
         end
         default: begin
            state_d = MAC_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= MAC_IDLE;
         address_q  <= '0;
         ea_q       <= '0;
         mem_data_q <= '0;
         op_load_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         address_q  <= address_d;
         ea_q       <= ea_d;
         mem_data_q <= mem_data_d;
         op_load_q  <= op_load_d;
      end
   end

   always_comb begin
      in_req          = (state_q == MAC_REQ);
      MemRead         = in_req && op_load_q;
      MemWrite        = in_req && !op_load_q;
      Write_data      = MemWrite ? st_data : '0;
      Write_strb      = MemWrite ? st_strb : '0;
      Read_data_Ready = (state_q == MAC_RDW);
      busy            = (state_q != MAC_IDLE);
      done            = (state_q == MAC_DONE);
      Address         = address_q;
      ea              = ea_q;
      mem_data        = mem_data_q;
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus randomized transactions
// checked against a cycle-timeline model derived from the transaction rules.
module tb_mem_access_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic        is_load;
   logic        is_store;
   logic [31:0] base;
   logic [15:0] offset;
   logic [31:0] st_data;
   logic [3:0]  st_strb;
   logic [31:0] Address;
   logic        MemRead;
   logic        MemWrite;
   logic        Address_Ready;
   logic [31:0] Write_data;
   logic [3:0]  Write_strb;
   logic [31:0] Read_data;
   logic        Read_data_Valid;
   logic        Read_data_Ready;
   logic [31:0] mem_data;
   logic [1:0]  ea;
   logic        busy;
   logic        done;

   int checks;
   int failures;

   logic [31:0] m_addr;
   logic [1:0]  m_ea;
   logic [31:0] m_mem;

   mem_access_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .is_load         (is_load),
      .is_store        (is_store),
      .base            (base),
      .offset          (offset),
      .st_data         (st_data),
      .st_strb         (st_strb),
      .Address         (Address),
      .MemRead         (MemRead),
      .MemWrite        (MemWrite),
      .Address_Ready   (Address_Ready),
      .Write_data      (Write_data),
      .Write_strb      (Write_strb),
      .Read_data       (Read_data),
      .Read_data_Valid (Read_data_Valid),
      .Read_data_Ready (Read_data_Ready),
      .mem_data        (mem_data),
      .ea              (ea),
      .busy            (busy),
      .done            (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".Address"}, Address, 32'h0);
      chk({tag, ".ea"}, {30'b0, ea}, 32'h0);
      chk({tag, ".mem_data"}, mem_data, 32'h0);
      chk({tag, ".Write_data"}, Write_data, 32'h0);
      chk({tag, ".Write_strb"}, {28'b0, Write_strb}, 32'h0);
      chk({tag, ".ctl"}, {27'b0, MemRead, MemWrite, Read_data_Ready, busy, done}, 32'h0);
   endtask

   // Runs one request; the expected timeline comes from the wait counts:
   // load = REQ for aw+1 cycles, RDW for vw+1 cycles, then DONE; store = REQ then DONE.
   task automatic run_txn(input string tag, input bit ld, input bit st,
                          input logic [31:0] b, input logic [15:0] off,
                          input int unsigned aw, input int unsigned vw,
                          input bit early_v, input bit extra_start);
      logic [31:0] eff_m, rd, decoy, sd, exp_addr, exp_mem;
      logic [3:0]  sb;
      logic [1:0]  exp_ea;
      bit          ldop, stop, in_req, in_rdw, is_dn, idle;
      int unsigned done_c;
      ldop   = ld;
      stop   = st && !ld;
      eff_m  = b + {{16{off[15]}}, off};
      done_c = ldop ? 3 + aw + vw : (stop ? 2 + aw : 1);
      rd     = $urandom;
      decoy  = ~rd;
      sd     = $urandom;
      sb     = 4'($urandom_range(0, 15));
      exp_addr = (ldop || stop) ? {eff_m[31:2], 2'b00} : m_addr;
      exp_ea   = (ldop || stop) ? eff_m[1:0] : m_ea;

      start = 1'b1; is_load = ld; is_store = st; base = b; offset = off;
      st_data = sd; st_strb = sb; Address_Ready = 1'b0;
      Read_data_Valid = 1'b0; Read_data = decoy;

      for (int unsigned c = 1; c <= done_c + 1; c++) begin
         step();
         start  = 1'b0;
         in_req = (ldop || stop) && (c <= 1 + aw);
         in_rdw = ldop && (c >= 2 + aw) && (c <= 2 + aw + vw);
         is_dn  = (c == done_c);
         idle   = (c > done_c);
         exp_mem = (ldop && c >= done_c) ? rd : m_mem;
         chk({tag, ".busy"}, {31'b0, busy}, {31'b0, !idle});
         chk({tag, ".done"}, {31'b0, done}, {31'b0, is_dn});
         chk({tag, ".MemRead"}, {31'b0, MemRead}, {31'b0, in_req && ldop});
         chk({tag, ".MemWrite"}, {31'b0, MemWrite}, {31'b0, in_req && stop});
         chk({tag, ".Read_data_Ready"}, {31'b0, Read_data_Ready}, {31'b0, in_rdw});
         chk({tag, ".Write_data"}, Write_data, (in_req && stop) ? sd : 32'h0);
         chk({tag, ".Write_strb"}, {28'b0, Write_strb}, (in_req && stop) ? {28'b0, sb} : 32'h0);
         chk({tag, ".Address"}, Address, exp_addr);
         chk({tag, ".ea"}, {30'b0, ea}, {30'b0, exp_ea});
         chk({tag, ".mem_data"}, mem_data, exp_mem);

         Address_Ready   = in_req && (c == 1 + aw);
         Read_data_Valid = (in_rdw && (c == 2 + aw + vw)) || (early_v && in_req);
         Read_data       = in_rdw ? rd : decoy;
         if (extra_start && ((in_req && c == 1) || is_dn)) begin
            start   = 1'b1;
            is_load = 1'b1;
         end
      end
      start = 1'b0; Address_Ready = 1'b0; Read_data_Valid = 1'b0;
      m_addr = exp_addr;
      m_ea   = exp_ea;
      if (ldop) m_mem = rd;
   endtask

   initial begin
      checks = 0; failures = 0;
      m_addr = '0; m_ea = '0; m_mem = '0;
      rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0;
      base = '0; offset = '0; st_data = '0; st_strb = '0;
      Address_Ready = 1'b0; Read_data = '0; Read_data_Valid = 1'b0;
      step();
      step();
      chk_all_zero("reset");
      rst = 1'b0;
      step();
      chk_all_zero("post_reset_idle");

      run_txn("load_zw",   1'b1, 1'b0, 32'h0000_1000, 16'hFFFE, 0, 0, 1'b0, 1'b0);
      chk("load_zw.addr_const", Address, 32'h0000_0FFC);
      run_txn("store_wait", 1'b0, 1'b1, 32'h0000_2001, 16'h0000, 3, 0, 1'b0, 1'b0);
      chk("store_wait.addr_const", Address, 32'h0000_2000);
      run_txn("wrap_load", 1'b1, 1'b0, 32'hFFFF_FFFE, 16'h0005, 0, 0, 1'b0, 1'b0);
      chk("wrap.addr_const", Address, 32'h0000_0000);
      chk("wrap.ea_const", {30'b0, ea}, 32'h3);
      run_txn("wrap_store", 1'b0, 1'b1, 32'h7FFF_FFFF, 16'h8001, 1, 0, 1'b0, 1'b0);
      run_txn("ignored",   1'b1, 1'b0, 32'h0000_4000, 16'h0013, 2, 1, 1'b1, 1'b1);
      run_txn("null_req",  1'b0, 1'b0, 32'h1234_5678, 16'h0004, 0, 0, 1'b0, 1'b1);
      run_txn("both_flags", 1'b1, 1'b1, 32'h0000_0100, 16'h0001, 1, 2, 1'b0, 1'b0);

      // Reset while waiting in RDW abandons the load.
      start = 1'b1; is_load = 1'b1; is_store = 1'b0; base = 32'h0000_8000; offset = 16'h0006;
      step();
      start = 1'b0; Address_Ready = 1'b1;
      step();
      Address_Ready = 1'b0;
      chk("rst_mid.in_rdw", {31'b0, Read_data_Ready}, 32'h1);
      rst = 1'b1;
      step();
      chk_all_zero("rst_mid.c1");
      step();
      chk_all_zero("rst_mid.c2");
      rst = 1'b0; Read_data_Valid = 1'b1; Read_data = 32'hCAFE_F00D;
      step();
      chk_all_zero("rst_mid.c3");
      Read_data_Valid = 1'b0;
      step();
      chk_all_zero("rst_mid.c4");
      m_addr = '0; m_ea = '0; m_mem = '0;

      for (int i = 0; i < 40; i++) begin
         run_txn("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom, 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle load/store bus controller for the MIPS core's memory stage. On a one-cycle `start` from the main control FSM, it computes the effective address and drives the word-aligned memory request handshake. For loads, it captures the returned word. It also supplies the byte offset `ea` and the captured word to the downstream load/store extender/merger, and it takes that block's store data and byte strobes back as the write payload.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request pulse; honoured only in IDLE
- `is_load`  in  1  request is a load (lw/lb/lh/lbu/lhu/lwl/lwr)
- `is_store`  in  1  request is a store (sw/sb/sh/swl/swr)
- `base`  in  32  rs register value
- `offset`  in  16  instruction immediate, sign-extended internally
- `st_data`  in  32  store data from extender, already lane-positioned
- `st_strb`  in  4  store byte strobes from extender
- `Address`  out  32  word-aligned request address
- `MemRead`  out  1  read request valid
- `MemWrite`  out  1  write request valid
- `Address_Ready`  in  1  memory accepts the request
- `Write_data`  out  32  write payload
- `Write_strb`  out  4  write byte enables
- `Read_data`  in  32  returned read word
- `Read_data_Valid`  in  1  read data valid
- `Read_data_Ready`  out  1  controller can accept read data
- `mem_data`  out  32  captured read word, to extender `mem_input`
- `ea`  out  2  effective address bits [1:0], to extender
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- Effective address: `eff = base + {{16{offset[15]}}, offset}`, modulo 2^32, so it wraps silently. There is no alignment exception.
- States: IDLE, REQ, RDW, DONE. All outputs are registered or Moore-decoded from the state.
- IDLE:
  - If `start` = 1 and (`is_load` or `is_store`), latch `Address = {eff[31:2], 2'b00}` and `ea = eff[1:0]`, latch the operation type, and go to REQ.
  - If `start` = 1 with neither type flag set, go straight to DONE with no bus activity.
  - If both type flags are set, `is_load` wins.
- REQ:
  - `MemRead` = load; `MemWrite` = store.
  - For stores, `Write_data` = `st_data` and `Write_strb` = `st_strb`, passed through combinationally. Otherwise they are 0.
  - When `Address_Ready` = 1: a load goes to RDW; a store goes to DONE.
  - Request outputs stay stable until acceptance.
- RDW:
  - `Read_data_Ready` = 1.
  - When `Read_data_Valid` = 1, capture `mem_data <= Read_data` and go to DONE.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE.
- `mem_data` and `ea` hold their values until the next capture or latch. The extender's output is therefore stable in IDLE after `done`.
- `start` while `busy` is ignored; no queueing.
- Upstream holds `base`, `offset`, and the register operand feeding `st_data` stable from `start` until `done`.

## Timing
- Reset (synchronous, at the edge where `rst` = 1):
  - State goes to IDLE.
  - `Address`, `mem_data`, `Write_data` reset to 32'h0.
  - `ea` = 0, `Write_strb` = 0.
  - `MemRead`, `MemWrite`, `Read_data_Ready`, `busy`, `done` = 0.
- Reset mid-transaction abandons the transaction. The request outputs drop in the cycle after the reset edge, and no `done` is issued.
- Load, zero wait: `start` in cycle 0, REQ in cycle 1 (`MemRead` = 1, `Address_Ready` = 1), RDW in cycle 2 (`Valid` = 1), `done` in cycle 3.
  - Minimum start-to-done latency is 3 cycles.
- Store, zero wait: `done` in cycle 2.
  - Minimum start-to-done latency is 2 cycles.
- Each cycle of `Address_Ready` = 0 in REQ, or `Read_data_Valid` = 0 in RDW, adds one cycle. There is no timeout.
- `Read_data_Valid` asserted while in REQ is ignored. Data is accepted only in RDW.
- `start` in the DONE cycle is ignored. A new request is accepted one cycle after `done`, so back-to-back throughput is one request per 4 cycles (load) or 3 cycles (store).

## Structure
- Shared package (with `define.v`): state encodings `MAC_IDLE`, `MAC_REQ`, `MAC_RDW`, `MAC_DONE` (2-bit).
- Single module, no sub-modules. The effective-address adder is inline.
- The extender is instantiated at the top level alongside this block, wired as follows:
  - `mem_data` → `mem_input`
  - `ea` → `ea`
  - `extender_output` / `strb` → `st_data` / `st_strb`
- There is no combinational loop, because `ea` is registered.

## Test plan
- **Reset:** `rst` held for 2 cycles mid-RDW → all outputs 0 next cycle, state IDLE, no `done`.
- **Load, zero wait:** `base` = 32'h1000, `offset` = 16'hFFFE, load, `Address_Ready` = 1, `Read_data` = 32'hDEADBEEF with `Valid` in cycle 2 → `Address` = 32'h00000FFC, `ea` = 2'b10, `mem_data` = 32'hDEADBEEF, `done` in cycle 3.
- **Store with waits:** `base` = 32'h2001, `offset` = 0, store, `st_strb` = 4'b0010, `Address_Ready` low for 3 cycles → `MemWrite` and `Address` = 32'h2000 held stable for 4 cycles, `Write_strb` = 4'b0010, `done` 1 cycle after acceptance.
- **Address wrap:** `base` = 32'hFFFFFFFE, `offset` = 16'h0005 → `Address` = 32'h00000000, `ea` = 2'b11.
- **Ignored inputs:** `start` pulsed during REQ, plus `Read_data_Valid` = 1 early in REQ → no second transaction, data captured only in RDW.
- **Null and conflicting requests:** `start` with neither flag set → `done` in cycle 1, no `MemRead`/`MemWrite`. Both flags set → load performed.
